// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: register offsets, bit
// positions and the request/service state encoding.
package irq_pkg;

    localparam int IPEND_OFS = 0;
    localparam int IMASK_OFS = 4;
    localparam int ICTRL_OFS = 8;
    localparam int ISERV_OFS = 12;

    localparam int ICTRL_GIE_BIT   = 0;
    localparam int ISERV_VALID_BIT = 31;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index wins. Pure combinational.
module irq_prio_enc #(
    parameter int N       = 4,
    parameter int ID_BITS = 2
) (
    input  logic [N-1:0]       req,
    output logic [ID_BITS-1:0] id,
    output logic               found
);

    // Scan from the top down so the last (lowest) set bit is what remains.
    always_comb begin
        id    = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                id    = ID_BITS'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture into IPEND, mask and global
// enable, fixed priority, and a single-entry request/ack/eoi sequencer.
module irq_controller
    import irq_pkg::*;
#(
    parameter int             BITS    = 32,
    parameter logic [BITS-1:0] BASE   = 32'hF0000200,
    parameter int             NUM_SRC = 4,
    parameter int             ID_BITS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic               re,
    input  logic [BITS-1:0]    memAddr,
    input  logic [BITS-1:0]    dataBusIn,
    output logic [BITS-1:0]    dataBusOut,
    input  logic [NUM_SRC-1:0] src,
    output logic               irq,
    output logic [ID_BITS-1:0] irq_id,
    input  logic               irq_ack,
    input  logic               irq_eoi
);

    logic [NUM_SRC-1:0] src_prev;
    logic [NUM_SRC-1:0] ipend;
    logic [NUM_SRC-1:0] imask;
    logic               gie;

    irq_state_e         state;
    irq_state_e         state_next;
    logic [ID_BITS-1:0] sel;
    logic [ID_BITS-1:0] sel_next;

    logic hit_ipend, hit_imask, hit_ictrl, hit_iserv;
    logic wr_ipend, wr_imask, wr_ictrl;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] sel_onehot;
    logic [NUM_SRC-1:0] w1c_clear;
    logic [NUM_SRC-1:0] ack_clear;
    logic               sel_pending;
    logic               ack_take;
    logic [ID_BITS-1:0] win_id;
    logic               win_found;

    logic unused_wdata;
    assign unused_wdata = ^dataBusIn[BITS-1:NUM_SRC];

    assign hit_ipend = (memAddr == BASE + BITS'(IPEND_OFS));
    assign hit_imask = (memAddr == BASE + BITS'(IMASK_OFS));
    assign hit_ictrl = (memAddr == BASE + BITS'(ICTRL_OFS));
    assign hit_iserv = (memAddr == BASE + BITS'(ISERV_OFS));

    assign wr_ipend = we & hit_ipend;
    assign wr_imask = we & hit_imask;
    assign wr_ictrl = we & hit_ictrl;

    assign rise        = src & ~src_prev;
    assign eligible    = ipend & imask;
    assign sel_onehot  = NUM_SRC'(1) << sel;
    assign sel_pending = |(ipend & sel_onehot);
    assign ack_take    = (state == REQ) & irq_ack;
    assign w1c_clear   = wr_ipend ? dataBusIn[NUM_SRC-1:0] : '0;
    assign ack_clear   = ack_take ? sel_onehot : '0;

    irq_prio_enc #(
        .N       (NUM_SRC),
        .ID_BITS (ID_BITS)
    ) u_prio_enc (
        .req   (eligible),
        .id    (win_id),
        .found (win_found)
    );

    // A new edge is OR'd in last so it survives a same-cycle W1C or ack clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src_prev <= '0;
            ipend    <= '0;
            imask    <= '0;
            gie      <= 1'b0;
        end else begin
            src_prev <= src;
            ipend    <= (ipend & ~w1c_clear & ~ack_clear) | rise;
            if (wr_imask) imask <= dataBusIn[NUM_SRC-1:0];
            if (wr_ictrl) gie   <= dataBusIn[ICTRL_GIE_BIT];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sel   <= '0;
        end else begin
            state <= state_next;
            sel   <= sel_next;
        end
    end

    // CPU handshake: irq stays high in REQ until a one-cycle irq_ack; the
    // source is then in service until a one-cycle irq_eoi. An ack in the same
    // cycle as a withdraw condition is honoured, since the CPU already took it.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        irq        = 1'b0;
        irq_id     = '0;
        case (state)
            IDLE: begin
                if (gie && win_found) begin
                    sel_next   = win_id;
                    state_next = REQ;
                end
            end
            REQ: begin
                irq    = 1'b1;
                irq_id = sel;
                if (irq_ack) begin
                    state_next = SERVICE;
                end else if (!gie || !sel_pending) begin
                    state_next = IDLE;
                end
            end
            SERVICE: begin
                irq_id = sel;
                if (irq_eoi) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        dataBusOut = '0;
        if (re) begin
            if (hit_ipend) begin
                dataBusOut[NUM_SRC-1:0] = ipend;
            end else if (hit_imask) begin
                dataBusOut[NUM_SRC-1:0] = imask;
            end else if (hit_ictrl) begin
                dataBusOut[ICTRL_GIE_BIT] = gie;
            end else if (hit_iserv && state == SERVICE) begin
                dataBusOut[ISERV_VALID_BIT] = 1'b1;
                dataBusOut[ID_BITS-1:0]     = sel;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the register and handshake rules.
module tb_irq_controller;

    localparam logic [31:0] A_IPEND = 32'hF0000200;
    localparam logic [31:0] A_IMASK = 32'hF0000204;
    localparam logic [31:0] A_ICTRL = 32'hF0000208;
    localparam logic [31:0] A_ISERV = 32'hF000020C;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, re;
    logic [31:0] memAddr, dataBusIn;
    logic [31:0] dataBusOut;
    logic [3:0]  src;
    logic        irq;
    logic [1:0]  irq_id;
    logic        irq_ack, irq_eoi;

    int total = 0;
    int bad   = 0;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .re         (re),
        .memAddr    (memAddr),
        .dataBusIn  (dataBusIn),
        .dataBusOut (dataBusOut),
        .src        (src),
        .irq        (irq),
        .irq_id     (irq_id),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        we = 1'b1; memAddr = addr; dataBusIn = data;
        tick();
        we = 1'b0; memAddr = '0; dataBusIn = '0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        re = 1'b1; memAddr = addr;
        #1;
        data = dataBusOut;
        re = 1'b0; memAddr = '0;
    endtask

    task automatic pulse_src(input logic [3:0] bits);
        src = bits;
        tick();
        src = '0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    endtask

    task automatic pulse_eoi();
        irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    endtask

    task automatic wait_irq(input int max_cycles, input string name);
        for (int k = 0; k < max_cycles && irq !== 1'b1; k++) tick();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL %s: irq=%b required 1 within %0d cycles", name, irq, max_cycles);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [31:0] addrs [4];
        addrs[0] = A_IPEND; addrs[1] = A_IMASK; addrs[2] = A_ICTRL; addrs[3] = A_ISERV;
        for (int i = 0; i < 4; i++) begin
            bus_read(addrs[i], d);
            total++;
            if (d !== 32'h0) begin
                bad++;
                $display("FAIL reset_read[%0d]: got %h required 0", i, d);
            end
        end
        total++;
        if (irq !== 1'b0 || irq_id !== 2'd0) begin
            bad++;
            $display("FAIL reset_irq: irq=%b id=%0d required 0/0", irq, irq_id);
        end
    endtask

    task automatic test_bus_decode();
        logic [31:0] d;
        bus_write(A_IMASK, 32'hFFFF_FFF6);
        bus_read(A_IMASK, d);
        total++;
        if (d !== 32'h6) begin bad++; $display("FAIL imask_width: got %h required 6", d); end
        re = 1'b0; memAddr = A_IMASK; #1;
        total++;
        if (dataBusOut !== 32'h0) begin bad++; $display("FAIL read_no_re: got %h required 0", dataBusOut); end
        re = 1'b1; memAddr = A_IPEND + 32'd16; #1;
        total++;
        if (dataBusOut !== 32'h0) begin bad++; $display("FAIL read_miss: got %h required 0", dataBusOut); end
        re = 1'b0; memAddr = '0;
        bus_write(A_ICTRL, 32'hFFFF_FFFF);
        bus_read(A_ICTRL, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL ictrl_width: got %h required 1", d); end
        bus_write(A_ISERV, 32'hFFFF_FFFF);
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL iserv_ro: got %h required 0", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        bus_write(A_IMASK, 32'h6);
        bus_write(A_ICTRL, 32'h1);
        pulse_src(4'b0100);
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL basic_ipend: got %h required 4", d); end
        wait_irq(2, "basic_irq");
        total++;
        if (irq_id !== 2'd2) begin bad++; $display("FAIL basic_id: got %0d required 2", irq_id); end
        pulse_ack();
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL basic_ack_ipend: got %h required 0", d); end
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h8000_0002) begin bad++; $display("FAIL basic_iserv: got %h required 80000002", d); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL basic_irq_low: irq=%b required 0", irq); end
        pulse_eoi();
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL basic_eoi_iserv: got %h required 0", d); end
    endtask

    task automatic test_priority();
        logic [31:0] d;
        bus_write(A_IMASK, 32'hF);
        pulse_src(4'b1010);
        wait_irq(2, "prio_first_irq");
        total++;
        if (irq_id !== 2'd1) begin bad++; $display("FAIL prio_first_id: got %0d required 1", irq_id); end
        pulse_ack();
        pulse_eoi();
        tick();
        total++;
        if (irq !== 1'b1 || irq_id !== 2'd3) begin
            bad++;
            $display("FAIL prio_back_to_back: irq=%b id=%0d required 1/3", irq, irq_id);
        end
        pulse_ack();
        pulse_eoi();
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL prio_drained: got %h required 0", d); end
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        pulse_src(4'b0001);
        wait_irq(2, "wd_w1c_irq");
        total++;
        if (irq_id !== 2'd0) begin bad++; $display("FAIL wd_w1c_id: got %0d required 0", irq_id); end
        bus_write(A_IPEND, 32'h1);
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL wd_w1c_drop: irq=%b required 0", irq); end
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL wd_w1c_iserv: got %h required 0", d); end
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL wd_w1c_stay: irq=%b required 0", irq); end

        pulse_src(4'b0001);
        wait_irq(2, "wd_gie_irq");
        bus_write(A_ICTRL, 32'h0);
        tick();
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL wd_gie_drop: irq=%b required 0", irq); end
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL wd_gie_pend_kept: got %h required 1", d); end
        bus_write(A_IPEND, 32'hF);
    endtask

    task automatic test_set_wins();
        logic [31:0] d;
        src = 4'b0010;
        bus_write(A_IPEND, 32'h2);
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h2) begin bad++; $display("FAIL set_wins: got %h required 2", d); end
        bus_write(A_IPEND, 32'h2);
        tick();
        tick();
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL held_no_recapture: got %h required 0", d); end
        src = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus_write(A_ICTRL, 32'h1);
        pulse_src(4'b0100);
        wait_irq(2, "rst_mid_irq");
        pulse_ack();
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h8000_0002) begin bad++; $display("FAIL rst_mid_in_service: got %h required 80000002", d); end
        reset = 1'b0;
        #1;
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL rst_mid_irq: irq=%b required 0", irq); end
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_iserv: got %h required 0", d); end
        bus_read(A_IMASK, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_imask: got %h required 0", d); end
        @(negedge clk);
        reset = 1'b1;
        tick();

        bus_write(A_IMASK, 32'hF);
        pulse_src(4'b0001);
        pulse_ack();
        pulse_eoi();
        bus_read(A_IPEND, d);
        total++;
        if (d !== 32'h1) begin bad++; $display("FAIL stray_ack_pend: got %h required 1", d); end
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL stray_iserv: got %h required 0", d); end
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL stray_irq: irq=%b required 0", irq); end
        bus_write(A_ICTRL, 32'h1);
        wait_irq(2, "stray_then_req");
        irq_ack = 1'b1; irq_eoi = 1'b1;
        tick();
        irq_ack = 1'b0; irq_eoi = 1'b0;
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h8000_0000) begin bad++; $display("FAIL ack_eoi_together: got %h required 80000000", d); end
        pulse_eoi();
        bus_read(A_ISERV, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL ack_eoi_done: got %h required 0", d); end
    endtask

    // Model: pending set, mask, enable, plus which source (if any) the CPU is
    // being asked to take or is currently handling.
    task automatic test_random();
        localparam int M_IDLE = 0, M_ASK = 1, M_BUSY = 2;
        logic [3:0]  m_pend, m_mask, m_prev, npend;
        bit          m_gie;
        int          m_mode, m_sel, nmode, nsel, op;
        logic [31:0] wdata, exp_rd;
        we = 0; re = 0; memAddr = '0; dataBusIn = '0; src = '0; irq_ack = 0; irq_eoi = 0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        m_pend = '0; m_mask = '0; m_prev = '0; m_gie = 0; m_mode = M_IDLE; m_sel = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            src     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
            irq_ack = ($urandom_range(0, 3) == 0);
            irq_eoi = ($urandom_range(0, 3) == 0);
            op      = $urandom_range(0, 11);
            wdata   = $urandom;
            we = 0; re = 0; memAddr = '0; dataBusIn = '0;
            case (op)
                0: begin we = 1; memAddr = A_IPEND; dataBusIn = wdata; end
                1: begin we = 1; memAddr = A_IMASK; dataBusIn = wdata; end
                2: begin wdata[0] = ($urandom_range(0, 4) != 0); we = 1; memAddr = A_ICTRL; dataBusIn = wdata; end
                3: begin we = 1; memAddr = A_ISERV; dataBusIn = wdata; end
                4: begin re = 1; memAddr = A_IPEND + 32'd16; end
                default: begin re = 1; memAddr = A_IPEND + 32'(4 * $urandom_range(0, 3)); end
            endcase
            #1;
            total++;
            if (irq !== (m_mode == M_ASK)) begin
                bad++;
                $display("FAIL rand_irq cyc=%0d: irq=%b required %b", cyc, irq, (m_mode == M_ASK));
            end
            if (m_mode != M_IDLE) begin
                total++;
                if (irq_id !== 2'(m_sel)) begin
                    bad++;
                    $display("FAIL rand_id cyc=%0d: id=%0d required %0d", cyc, irq_id, m_sel);
                end
            end
            if (re) begin
                if (memAddr == A_IPEND)      exp_rd = {28'b0, m_pend};
                else if (memAddr == A_IMASK) exp_rd = {28'b0, m_mask};
                else if (memAddr == A_ICTRL) exp_rd = {31'b0, m_gie};
                else if (memAddr == A_ISERV) exp_rd = (m_mode == M_BUSY) ? (32'h8000_0000 | 32'(m_sel)) : 32'h0;
                else                         exp_rd = 32'h0;
                total++;
                if (dataBusOut !== exp_rd) begin
                    bad++;
                    $display("FAIL rand_read cyc=%0d addr=%h: got %h required %h", cyc, memAddr, dataBusOut, exp_rd);
                end
            end
            @(posedge clk);
            npend = m_pend;
            nmode = m_mode;
            nsel  = m_sel;
            if (we && memAddr == A_IPEND) npend = npend & ~dataBusIn[3:0];
            if (m_mode == M_ASK && irq_ack) npend[m_sel] = 1'b0;
            npend = npend | (src & ~m_prev);
            if (m_mode == M_IDLE) begin
                if (m_gie && (m_pend & m_mask) != 4'b0) begin
                    for (int i = 3; i >= 0; i--) if (m_pend[i] && m_mask[i]) nsel = i;
                    nmode = M_ASK;
                end
            end else if (m_mode == M_ASK) begin
                if (irq_ack) nmode = M_BUSY;
                else if (!m_gie || !m_pend[m_sel]) nmode = M_IDLE;
            end else begin
                if (irq_eoi) nmode = M_IDLE;
            end
            if (we && memAddr == A_IMASK) m_mask = dataBusIn[3:0];
            if (we && memAddr == A_ICTRL) m_gie = dataBusIn[0];
            m_pend = npend;
            m_mode = nmode;
            m_sel  = nsel;
            m_prev = src;
            #1;
        end
        we = 0; re = 0; memAddr = '0; dataBusIn = '0; src = '0; irq_ack = 0; irq_eoi = 0;
    endtask

    initial begin
        reset = 1'b0; we = 0; re = 0; memAddr = '0; dataBusIn = '0;
        src = '0; irq_ack = 0; irq_eoi = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        test_reset();
        test_bus_decode();
        test_basic();
        test_priority();
        test_withdraw();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Memory-mapped interrupt controller on the shared OR'd data bus (we/re/memAddr/dataBus).
- Captures rising edges on device interrupt lines (timer, key, switch, ...) into pending bits and applies a mask and a global enable.
- Selects the highest-priority source and runs a request/acknowledge/end-of-interrupt handshake with the CPU.
- Sequences access to the CPU's single interrupt entry: exactly one source is in service at a time.

Parameters:
- BITS, 32, bus data/address width
- BASE, 32'hF0000200, address of IPEND; IMASK=BASE+4, ICTRL=BASE+8, ISERV=BASE+12
- NUM_SRC, 4, number of interrupt sources (1..16)
- ID_BITS, 2, width of source id; must satisfy 2^ID_BITS >= NUM_SRC

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- we  in  1  bus write strobe
- re  in  1  bus read strobe
- memAddr  in  BITS  bus address
- dataBusIn  in  BITS  bus write data
- dataBusOut  out  BITS  read data; all zeros when this block is not addressed by a read
- src  in  NUM_SRC  device interrupt lines, synchronous to clk
- irq  out  1  interrupt request to CPU
- irq_id  out  ID_BITS  id of the requesting or in-service source
- irq_ack  in  1  one-cycle pulse: CPU has taken the interrupt
- irq_eoi  in  1  one-cycle pulse: CPU has finished the handler

Behaviour:
- Reset (reset=0, async):
  - IPEND=0, IMASK=0, ICTRL=0, state=IDLE.
  - src_prev=0.
  - irq=0, irq_id=0, dataBusOut=0.
- Edge capture:
  - rise[i] = src[i] & ~src_prev[i]; src_prev is registered every cycle.
  - A rise sets IPEND[i] on the next posedge.
  - When a rise and a W1C clear of the same bit land in the same cycle, the set wins.
- Register access:
  - Writes take effect at posedge when we=1 and memAddr matches.
  - Reads are combinational: dataBusOut = register when re=1 and memAddr matches, otherwise 0. Unused upper bits read 0.
  - IPEND: read pending bits; a write clears each bit written as 1 (W1C).
  - IMASK: R/W; 1 = source enabled.
  - ICTRL: R/W; bit0 = GIE (global enable), other bits read 0.
  - ISERV: read-only; bit31 = in-service valid, bits[ID_BITS-1:0] = in-service id. Writes are ignored.
- Eligibility and priority:
  - eligible = IPEND & IMASK.
  - Priority is fixed: the lowest index wins.
- FSM:
  - IDLE: if GIE and eligible!=0, latch sel = the winning id, go to REQ. irq rises one cycle after eligibility is seen.
  - REQ:
    - irq=1, irq_id=sel.
    - On irq_ack: clear IPEND[sel] and go to SERVICE.
    - If, before ack, IPEND[sel] is cleared by software or GIE drops to 0: deassert irq and return to IDLE (withdraw). sel is re-evaluated from IDLE.
    - A higher-priority arrival while in REQ does not preempt sel.
  - SERVICE:
    - irq=0, irq_id=sel, ISERV valid=1.
    - No new request is issued; new edges still set IPEND.
    - On irq_eoi: go to IDLE. Next request at the earliest one cycle later (back-to-back is allowed).
- Handshake misuse:
  - irq_ack outside REQ is ignored.
  - irq_eoi outside SERVICE is ignored.
  - irq_ack and irq_eoi asserted together in REQ: treat as ack only.
- Masking: changing IMASK never clears IPEND. Unmasking a pending bit raises a request from IDLE.
- Reset mid-operation returns to IDLE and drops irq immediately (asynchronous).

Decomposition:
- Shared package (irq_pkg):
  - register offsets IPEND_OFS=0, IMASK_OFS=4, ICTRL_OFS=8, ISERV_OFS=12
  - FSM state encoding IDLE/REQ/SERVICE
  - ICTRL_GIE_BIT=0, ISERV_VALID_BIT=31
- One sub-module: irq_prio_enc. Combinational lowest-index-first encoder over NUM_SRC bits; outputs id and a found flag.

Test Plan:
- Reset then read all four registers: each reads 0. Check dataBusOut=0 whenever re=0 or the address misses.
- Write IMASK=4'b0110 and ICTRL=1, pulse src[2]:
  - IPEND reads 4'b0100.
  - irq=1 with irq_id=2 within 2 cycles.
  - After irq_ack: IPEND=0, ISERV=32'h80000002.
  - After irq_eoi: ISERV=0.
- Pulse src[3] and src[1] in the same cycle with IMASK=4'hF:
  - First request irq_id=1.
  - After ack and eoi, irq_id=3 the next cycle.
- Withdraw:
  - Enter REQ on id 0, then W1C-write IPEND=1 before ack: irq drops and the FSM returns to IDLE.
  - Same test with GIE cleared instead of the W1C write gives the same result.
- Same-cycle src[1] rise and W1C of bit 1: IPEND[1]=1 afterwards. Holding src high gives no second capture.
- Assert reset=0 while in SERVICE: irq=0, ISERV=0, IMASK=0 immediately. Stray irq_ack and irq_eoi in IDLE cause no state change.
